// File: rtl/meas_uart_pkg.sv
// Shared types and constants for the measurement UART transmitter.
package meas_uart_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [1:0] HDR_H = 2'b10;
  localparam logic [1:0] HDR_L = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Header bits let the receiver tell the high and low halves of a sample apart.
  function automatic logic [7:0] frame_byte(input logic [SAMPLE_W-1:0] s, input logic hi);
    return hi ? {HDR_H, s[11:6]} : {HDR_L, s[5:0]};
  endfunction

endpackage

// File: rtl/meas_sync_fifo.sv
// Single-clock sample FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module meas_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/meas_uart_tx.sv
// Streams 12-bit measurement samples out as two 8N1 bytes (high half first) on ms_utx.
module meas_uart_tx
  import meas_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          prim_clk,
  input  logic                          prim_rst,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           meas_data,
  input  logic                          meas_data_p,
  input  logic                          ovf_clr,
  output logic                          ms_utx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t           state;
  logic [TW-1:0]       timer;
  logic [2:0]          bit_cnt;
  logic [7:0]          tx_byte;
  logic [SAMPLE_W-1:0] sample;
  logic                send_hi;
  logic                bit_end;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_drop;
  logic [SAMPLE_W-1:0] fifo_rdata;

  assign bit_end = (timer == T_LAST);
  // The head is consumed when a new high byte is about to start: from idle, or
  // straight after the low byte's stop bit so samples run back to back.
  assign pop  = !fifo_empty &&
                ((state == IDLE) || (state == STOP && bit_end && !send_hi));
  assign busy = (state != IDLE) || !fifo_empty;

  meas_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (prim_clk),
    .rst   (prim_rst),
    .push  (meas_data_p && enable),
    .pop   (pop),
    .wdata (meas_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .level (fifo_level)
  );

  always_ff @(posedge prim_clk) begin
    if (prim_rst)       overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clr)   overflow <= 1'b0;
  end

  // ms_utx is loaded with the level of the state being entered, so the line is registered.
  always_ff @(posedge prim_clk) begin
    if (prim_rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      send_hi <= 1'b0;
      ms_utx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          timer  <= '0;
          ms_utx <= 1'b1;
          if (!fifo_empty) begin
            state   <= START;
            sample  <= fifo_rdata;
            tx_byte <= frame_byte(fifo_rdata, 1'b1);
            send_hi <= 1'b1;
            ms_utx  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            state   <= DATA;
            bit_cnt <= '0;
            ms_utx  <= tx_byte[0];
            tx_byte <= tx_byte >> 1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_cnt == 3'd7) begin
              state  <= STOP;
              ms_utx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              ms_utx  <= tx_byte[0];
              tx_byte <= tx_byte >> 1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (send_hi) begin
              state   <= START;
              tx_byte <= frame_byte(sample, 1'b0);
              send_hi <= 1'b0;
              ms_utx  <= 1'b0;
            end else if (!fifo_empty) begin
              state   <= START;
              sample  <= fifo_rdata;
              tx_byte <= frame_byte(fifo_rdata, 1'b1);
              send_hi <= 1'b1;
              ms_utx  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          ms_utx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_uart_tx.sv
// Scoreboarded bench: a line monitor decodes 8N1 bytes and compares them to queued expectations.
module tb_meas_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int BYTE_CYC = 10 * CPB;

  logic        prim_clk = 1'b0;
  logic        prim_rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] meas_data = 12'h000;
  logic        meas_data_p = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        ms_utx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  meas_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .prim_clk    (prim_clk),
    .prim_rst    (prim_rst),
    .enable      (enable),
    .meas_data   (meas_data),
    .meas_data_p (meas_data_p),
    .ovf_clr     (ovf_clr),
    .ms_utx      (ms_utx),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 prim_clk = ~prim_clk;
  always @(posedge prim_clk) cyc <= cyc + 1;

  function automatic logic [7:0] hi_byte(input logic [11:0] d);
    return {2'b10, d[11:6]};
  endfunction

  function automatic logic [7:0] lo_byte(input logic [11:0] d);
    return {2'b01, d[5:0]};
  endfunction

  // Line monitor: sample mid-bit on the falling edge; reset abandons a partial byte.
  logic       rx_act = 1'b0;
  int         rx_off = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_exp = 8'h00;
  initial begin
    forever begin
      @(negedge prim_clk);
      if (prim_rst) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (ms_utx === 1'b0) begin
          rx_act = 1'b1;
          rx_off = 0;
          start_q.push_back(cyc);
        end
      end else begin
        rx_off++;
        if (rx_off == CPB / 2) begin
          vectors++;
          if (ms_utx !== 1'b0) begin
            miscompares++;
            $display("FAIL start_bit: line=%b required 0 (cycle %0d)", ms_utx, cyc);
          end
        end else if (rx_off > CPB && rx_off < 9 * CPB && (rx_off % CPB) == CPB / 2) begin
          rx_byte[rx_off / CPB - 1] = ms_utx;
        end else if (rx_off == 9 * CPB + CPB / 2) begin
          vectors++;
          if (ms_utx !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_bit: line=%b required 1 (cycle %0d)", ms_utx, cyc);
          end
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rx_byte: got %h, required none (cycle %0d)", rx_byte, cyc);
          end else begin
            rx_exp = exp_q.pop_front();
            if (rx_byte !== rx_exp) begin
              miscompares++;
              $display("FAIL rx_byte: got %h, required %h (cycle %0d)", rx_byte, rx_exp, cyc);
            end
          end
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge prim_clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] d, input bit accept);
    meas_data   = d;
    meas_data_p = 1'b1;
    if (accept) begin
      exp_q.push_back(hi_byte(d));
      exp_q.push_back(lo_byte(d));
    end
    tick();
    meas_data_p = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle(output int end_cyc);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    end_cyc = cyc;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: busy=%b required 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    prim_rst    = 1'b1;
    enable      = 1'b1;
    meas_data   = 12'hFFF;
    meas_data_p = 1'b1;
    ovf_clr     = 1'b1;
    repeat (3) tick();
    meas_data_p = 1'b0;
    ovf_clr     = 1'b0;
    vectors++; if (ms_utx !== 1'b1)      begin miscompares++; $display("FAIL rst_line: %b required 1", ms_utx); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: %b required 0", busy); end
    vectors++; if (overflow !== 1'b0)    begin miscompares++; $display("FAIL rst_ovf: %b required 0", overflow); end
    vectors++; if (fifo_level !== 3'd0)  begin miscompares++; $display("FAIL rst_level: %0d required 0", fifo_level); end
    prim_rst = 1'b0;
    tick();
    vectors++; if (fifo_level !== 3'd0)  begin miscompares++; $display("FAIL post_rst_level: %0d required 0", fifo_level); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL post_rst_busy: %b required 0", busy); end
  endtask

  task automatic test_single();
    int c0, s, e;
    start_q.delete();
    c0 = cyc;
    strobe(12'hA5C, 1'b1);
    vectors++; if (ms_utx !== 1'b1)     begin miscompares++; $display("FAIL single_pre_line: %b required 1", ms_utx); end
    vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL single_level1: %0d required 1", fifo_level); end
    tick();
    s = c0 + 2;
    vectors++; if (ms_utx !== 1'b0)     begin miscompares++; $display("FAIL single_latency: line=%b required 0 at N+2", ms_utx); end
    vectors++; if (busy !== 1'b1)       begin miscompares++; $display("FAIL single_busy: %b required 1", busy); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL single_level0: %0d required 0", fifo_level); end
    wait_until(s + 79);
    vectors++; if (busy !== 1'b1)       begin miscompares++; $display("FAIL single_busy_last: %b required 1", busy); end
    tick();
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL single_busy_end: %b required 0", busy); end
    vectors++; if (ms_utx !== 1'b1)     begin miscompares++; $display("FAIL single_line_end: %b required 1", ms_utx); end
    wait_idle(e);
    vectors++; if (start_q.size() != 2) begin miscompares++; $display("FAIL single_frames: %0d required 2", start_q.size()); end
    else begin
      vectors++; if (start_q[0] != s)            begin miscompares++; $display("FAIL single_start: %0d required %0d", start_q[0], s); end
      vectors++; if (start_q[1] != s + BYTE_CYC) begin miscompares++; $display("FAIL single_lo_start: %0d required %0d", start_q[1], s + BYTE_CYC); end
    end
    vectors++; if (exp_q.size() != 0)   begin miscompares++; $display("FAIL single_pending: %0d required 0", exp_q.size()); end
  endtask

  task automatic check_contiguous(input int n_frames);
    vectors++;
    if (start_q.size() != n_frames) begin
      miscompares++;
      $display("FAIL frame_count: %0d required %0d", start_q.size(), n_frames);
    end
    for (int i = 1; i < start_q.size(); i++) begin
      vectors++;
      if (start_q[i] - start_q[i-1] != BYTE_CYC) begin
        miscompares++;
        $display("FAIL frame_gap: %0d cycles required %0d (frame %0d)", start_q[i] - start_q[i-1], BYTE_CYC, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d [6] = '{12'h123, 12'hFFF, 12'h000, 12'h9C3, 12'h5A5, 12'h777};
    int c0, e;
    start_q.delete();
    c0 = cyc;
    for (int i = 0; i < 6; i++) strobe(d[i], i < 5);
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL b2b_level: %0d required 4", fifo_level); end
    vectors++; if (overflow !== 1'b1)   begin miscompares++; $display("FAIL b2b_ovf: %b required 1", overflow); end
    wait_idle(e);
    vectors++; if (e != c0 + 2 + 400)   begin miscompares++; $display("FAIL b2b_duration: ends %0d required %0d", e, c0 + 402); end
    check_contiguous(10);
    vectors++; if (exp_q.size() != 0)   begin miscompares++; $display("FAIL b2b_pending: %0d required 0", exp_q.size()); end
  endtask

  task automatic test_ovf_clr_full_pop();
    int c0, s, e;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL ovf_clear: %b required 0", overflow); end
    start_q.delete();
    c0 = cyc;
    s  = c0 + 2;
    for (int i = 0; i < 6; i++) strobe(12'h0F0 + 12'(i * 37), i < 5);
    ovf_clr = 1'b1;
    strobe(12'hDEA, 1'b0);
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b1)   begin miscompares++; $display("FAIL ovf_set_wins: %b required 1", overflow); end
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL ovf_level: %0d required 4", fifo_level); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL ovf_clear2: %b required 0", overflow); end
    wait_until(s + 79);
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL full_before_pop: %0d required 4", fifo_level); end
    strobe(12'h8B1, 1'b1);
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("FAIL full_pop_level: %0d required 4", fifo_level); end
    vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL full_pop_ovf: %b required 0", overflow); end
    wait_idle(e);
    check_contiguous(12);
    vectors++; if (exp_q.size() != 0)   begin miscompares++; $display("FAIL full_pop_pending: %0d required 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    int e;
    start_q.delete();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) strobe(12'($urandom_range(0, 4095)), 1'b0);
    repeat (3) tick();
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL en_level: %0d required 0", fifo_level); end
    vectors++; if (ms_utx !== 1'b1)     begin miscompares++; $display("FAIL en_line: %b required 1", ms_utx); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL en_busy: %b required 0", busy); end
    enable = 1'b1;
    strobe(12'h3C5, 1'b1);
    repeat (10) tick();
    enable = 1'b0;
    strobe(12'h111, 1'b0);
    strobe(12'h222, 1'b0);
    wait_idle(e);
    check_contiguous(2);
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL en_mid_level: %0d required 0", fifo_level); end
    vectors++; if (exp_q.size() != 0)   begin miscompares++; $display("FAIL en_pending: %0d required 0", exp_q.size()); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int c0, s, e;
    start_q.delete();
    c0 = cyc;
    s  = c0 + 2;
    strobe(12'hB71, 1'b1);
    strobe(12'h2E4, 1'b1);
    wait_until(s + 57);
    vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL rmid_level_pre: %0d required 1", fifo_level); end
    prim_rst = 1'b1;
    tick();
    vectors++; if (ms_utx !== 1'b1)     begin miscompares++; $display("FAIL rmid_line: %b required 1", ms_utx); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rmid_level: %0d required 0", fifo_level); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rmid_busy: %b required 0", busy); end
    tick();
    prim_rst = 1'b0;
    exp_q.delete();
    repeat (2 * BYTE_CYC) tick();
    vectors++; if (ms_utx !== 1'b1)     begin miscompares++; $display("FAIL rmid_no_resume: %b required 1", ms_utx); end
    start_q.delete();
    strobe(12'h6D8, 1'b1);
    wait_idle(e);
    check_contiguous(2);
    vectors++; if (exp_q.size() != 0)   begin miscompares++; $display("FAIL rmid_pending: %0d required 0", exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ovf_clr_full_pop();
    test_enable();
    test_reset_mid_frame();
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
